// File: rtl/game_state_controller.sv
// Match sequencer: start screen, play, level clear and game over. Turns per-pixel
// hit/door flags into per-frame life losses and runs both invulnerability timers.
module game_state_controller #(
    parameter int LIVES_INIT    = 3,
    parameter int LIVES_W       = 2,
    parameter int INVULN_FRAMES = 60,
    parameter int INVULN_W      = 8,
    parameter int END_FRAMES    = 90,
    parameter int LEVEL_W       = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               startOfFrame,
    input  logic               start_button,
    input  logic               player_hit,
    input  logic               player2_hit,
    input  logic               player_door_idol,
    output logic [1:0]         game_state,
    output logic [LIVES_W-1:0] lives1,
    output logic [LIVES_W-1:0] lives2,
    output logic               player_invulnerable,
    output logic               player2_invulnerable,
    output logic               player_alive,
    output logic               player2_alive,
    output logic [LEVEL_W-1:0] level,
    output logic               new_level_pulse,
    output logic               game_over
);

    localparam int END_W = $clog2(END_FRAMES + 1);

    localparam logic [LIVES_W-1:0]  LIVES_LOAD  = LIVES_W'(LIVES_INIT);
    localparam logic [INVULN_W-1:0] INVULN_LOAD = INVULN_W'(INVULN_FRAMES);
    localparam logic [END_W-1:0]    END_LOAD    = END_W'(END_FRAMES);
    localparam logic [END_W-1:0]    END_LAST    = END_W'(1);
    localparam logic [LEVEL_W-1:0]  LEVEL_MAX   = '1;

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_PLAY       = 2'd1,
        S_LEVEL_DONE = 2'd2,
        S_GAME_OVER  = 2'd3
    } state_t;

    typedef struct packed {
        logic [LIVES_W-1:0]  lives;
        logic [INVULN_W-1:0] invuln;
    } player_t;

    state_t              state, state_nxt;
    logic [LIVES_W-1:0]  lives1_nxt, lives2_nxt;
    logic [INVULN_W-1:0] invuln1, invuln2, invuln1_nxt, invuln2_nxt;
    logic [LEVEL_W-1:0]  level_nxt;
    logic [END_W-1:0]    end_cnt, end_cnt_nxt;
    logic                hit1_latch, hit2_latch, door_latch;
    logic                hit1_latch_nxt, hit2_latch_nxt, door_latch_nxt;
    logic                start_prev, start_prev_nxt;
    logic                new_level_nxt;
    logic                hit1_set, hit2_set, door_set;
    player_t             p1_upd, p2_upd;

    // One frame's worth of life/timer bookkeeping for a single player.
    function automatic player_t frame_update(input player_t cur, input logic hit);
        player_t upd;
        upd = cur;
        if (hit && cur.lives != '0) begin
            upd.lives  = cur.lives - 1'b1;
            upd.invuln = INVULN_LOAD;
        end else if (cur.invuln != '0) begin
            upd.invuln = cur.invuln - 1'b1;
        end
        return upd;
    endfunction

    assign game_state           = state;
    assign game_over            = (state == S_GAME_OVER);
    assign player_alive         = (lives1 != '0);
    assign player2_alive        = (lives2 != '0);
    assign player_invulnerable  = (invuln1 != '0);
    assign player2_invulnerable = (invuln2 != '0);

    assign hit1_set = (state == S_PLAY) && player_hit  && player_alive  && (invuln1 == '0);
    assign hit2_set = (state == S_PLAY) && player2_hit && player2_alive && (invuln2 == '0);
    assign door_set = (state == S_PLAY) && player_door_idol;

    assign p1_upd = frame_update(player_t'({lives1, invuln1}), hit1_latch);
    assign p2_upd = frame_update(player_t'({lives2, invuln2}), hit2_latch);

    always_comb begin
        // NOTE: every signal written here gets a default first, so no latch is inferred.
        state_nxt      = state;
        lives1_nxt     = lives1;
        lives2_nxt     = lives2;
        invuln1_nxt    = invuln1;
        invuln2_nxt    = invuln2;
        level_nxt      = level;
        end_cnt_nxt    = end_cnt;
        new_level_nxt  = 1'b0;
        start_prev_nxt = start_button;

        // A flag seen on the frame-start cycle itself belongs to the next frame.
        hit1_latch_nxt = (startOfFrame ? 1'b0 : hit1_latch) | hit1_set;
        hit2_latch_nxt = (startOfFrame ? 1'b0 : hit2_latch) | hit2_set;
        door_latch_nxt = (startOfFrame ? 1'b0 : door_latch) | door_set;
        if (state != S_PLAY) begin
            hit1_latch_nxt = 1'b0;
            hit2_latch_nxt = 1'b0;
            door_latch_nxt = 1'b0;
        end

        case (state)
            S_IDLE: begin
                if (start_button) begin
                    state_nxt     = S_PLAY;
                    lives1_nxt    = LIVES_LOAD;
                    lives2_nxt    = LIVES_LOAD;
                    level_nxt     = '0;
                    invuln1_nxt   = INVULN_LOAD;
                    invuln2_nxt   = INVULN_LOAD;
                    new_level_nxt = 1'b1;
                end
            end

            S_PLAY: begin
                if (startOfFrame) begin
                    lives1_nxt  = p1_upd.lives;
                    invuln1_nxt = p1_upd.invuln;
                    lives2_nxt  = p2_upd.lives;
                    invuln2_nxt = p2_upd.invuln;
                    // Losing the last life outranks reaching the door in the same frame.
                    if (p1_upd.lives == '0 && p2_upd.lives == '0) begin
                        state_nxt = S_GAME_OVER;
                    end else if (door_latch) begin
                        state_nxt   = S_LEVEL_DONE;
                        end_cnt_nxt = END_LOAD;
                    end
                end
            end

            S_LEVEL_DONE: begin
                if (startOfFrame) begin
                    if (end_cnt == END_LAST) begin
                        state_nxt     = S_PLAY;
                        end_cnt_nxt   = '0;
                        level_nxt     = (level == LEVEL_MAX) ? level : level + 1'b1;
                        new_level_nxt = 1'b1;
                        if (player_alive)  invuln1_nxt = INVULN_LOAD;
                        if (player2_alive) invuln2_nxt = INVULN_LOAD;
                    end else begin
                        end_cnt_nxt = end_cnt - 1'b1;
                    end
                end
            end

            S_GAME_OVER: begin
                if (start_button && !start_prev) begin
                    state_nxt = S_IDLE;
                end
            end

            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register updates from pre-edge values.
        if (reset) begin
            state           <= S_IDLE;
            lives1          <= '0;
            lives2          <= '0;
            invuln1         <= '0;
            invuln2         <= '0;
            level           <= '0;
            end_cnt         <= '0;
            hit1_latch      <= 1'b0;
            hit2_latch      <= 1'b0;
            door_latch      <= 1'b0;
            start_prev      <= 1'b0;
            new_level_pulse <= 1'b0;
        end else begin
            state           <= state_nxt;
            lives1          <= lives1_nxt;
            lives2          <= lives2_nxt;
            invuln1         <= invuln1_nxt;
            invuln2         <= invuln2_nxt;
            level           <= level_nxt;
            end_cnt         <= end_cnt_nxt;
            hit1_latch      <= hit1_latch_nxt;
            hit2_latch      <= hit2_latch_nxt;
            door_latch      <= door_latch_nxt;
            start_prev      <= start_prev_nxt;
            new_level_pulse <= new_level_nxt;
        end
    end

endmodule

// File: tb/tb_game_state_controller.sv
// Scoreboard bench for game_state_controller: stimulus queues expected output
// changes (with the frame they must appear in); a negedge monitor pops on each change.
module tb_game_state_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic       startOfFrame;
    logic       start_button;
    logic       player_hit;
    logic       player2_hit;
    logic       player_door_idol;
    logic [1:0] game_state;
    logic [1:0] lives1, lives2;
    logic       player_invulnerable, player2_invulnerable;
    logic       player_alive, player2_alive;
    logic [2:0] level;
    logic       new_level_pulse;
    logic       game_over;

    game_state_controller dut (
        .clk                  (clk),
        .reset                (reset),
        .startOfFrame         (startOfFrame),
        .start_button         (start_button),
        .player_hit           (player_hit),
        .player2_hit          (player2_hit),
        .player_door_idol     (player_door_idol),
        .game_state           (game_state),
        .lives1               (lives1),
        .lives2               (lives2),
        .player_invulnerable  (player_invulnerable),
        .player2_invulnerable (player2_invulnerable),
        .player_alive         (player_alive),
        .player2_alive        (player2_alive),
        .level                (level),
        .new_level_pulse      (new_level_pulse),
        .game_over            (game_over)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [1:0] st;
        logic [1:0] l1;
        logic [1:0] l2;
        logic [2:0] lvl;
        logic       nlp;
        logic       i1;
        logic       i2;
        int         fr;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          frame_no = 0;
    bit          mon_en = 1'b0;
    int          nlp_len = 0;
    logic [14:0] obs, prev_obs, exp_vec;
    exp_t        e;

    assign obs = {game_state, lives1, lives2, level, new_level_pulse,
                  player_invulnerable, player2_invulnerable,
                  game_over, player_alive, player2_alive};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t frame=%0d)", name, act, expv, $time, frame_no);
        end
    endtask

    task automatic expect_ev(input string name, input int st, input int l1, input int l2,
                             input int lvl, input int nlp, input int i1, input int i2, input int fr);
        exp_t r;
        r.name = name;
        r.st   = 2'(st);
        r.l1   = 2'(l1);
        r.l2   = 2'(l2);
        r.lvl  = 3'(lvl);
        r.nlp  = 1'(nlp);
        r.i1   = 1'(i1);
        r.i2   = 1'(i2);
        r.fr   = fr;
        exp_q.push_back(r);
    endtask

    // Monitor: any change in the observed outputs must match the next queued expectation.
    always @(negedge clk) begin
        if (!mon_en) begin
            prev_obs = obs;
        end else begin
            if (obs !== prev_obs) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output_change", {17'd0, obs}, {17'd0, prev_obs});
                end else begin
                    e = exp_q.pop_front();
                    exp_vec = {e.st, e.l1, e.l2, e.lvl, e.nlp, e.i1, e.i2,
                               (e.st == 2'd3), (e.l1 != 2'd0), (e.l2 != 2'd0)};
                    check(e.name, {17'd0, obs}, {17'd0, exp_vec});
                    check({e.name, "_frame"}, frame_no, e.fr);
                end
                prev_obs = obs;
            end
            if (new_level_pulse) begin
                nlp_len++;
            end else if (nlp_len != 0) begin
                check("new_level_pulse_width", nlp_len, 1);
                nlp_len = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One frame of len cycles; flags held for their first N cycles, startOfFrame on the last.
    task automatic frame(input int len, input int h1n, input int h2n, input int dn,
                         input logic [2:0] sof_mask);
        for (int c = 0; c < len - 1; c++) begin
            player_hit       = (c < h1n);
            player2_hit      = (c < h2n);
            player_door_idol = (c < dn);
            startOfFrame     = 1'b0;
            tick();
        end
        player_hit       = sof_mask[0];
        player2_hit      = sof_mask[1];
        player_door_idol = sof_mask[2];
        startOfFrame     = 1'b1;
        tick();
        frame_no++;
        startOfFrame     = 1'b0;
        player_hit       = 1'b0;
        player2_hit      = 1'b0;
        player_door_idol = 1'b0;
    endtask

    task automatic run_frames(input int n);
        for (int i = 0; i < n; i++) frame(4, 0, 0, 0, 3'b000);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_state"},  game_state, 0);
        check({tag, "_lives1"}, lives1, 0);
        check({tag, "_lives2"}, lives2, 0);
        check({tag, "_level"},  level, 0);
        check({tag, "_nlp"},    new_level_pulse, 0);
        check({tag, "_inv1"},   player_invulnerable, 0);
        check({tag, "_inv2"},   player2_invulnerable, 0);
        check({tag, "_gover"},  game_over, 0);
        check({tag, "_alive1"}, player_alive, 0);
        check({tag, "_alive2"}, player2_alive, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout at frame %0d", frame_no);
        $fatal(1, "watchdog");
    end

    initial begin
        int nxt;
        reset            = 1'b1;
        startOfFrame     = 1'b0;
        start_button     = 1'b0;
        player_hit       = 1'b0;
        player2_hit      = 1'b0;
        player_door_idol = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check_reset_outputs("reset");
        mon_en = 1'b1;

        // Start: lives 3/3, level 0, one-cycle reload pulse, both invulnerable for 60 frames.
        expect_ev("start",           1, 3, 3, 0, 1, 1, 1, frame_no);
        expect_ev("start_pulse_end", 1, 3, 3, 0, 0, 1, 1, frame_no);
        expect_ev("spawn_inv_end",   1, 3, 3, 0, 0, 0, 0, frame_no + 60);
        start_button = 1'b1;
        tick();
        start_button = 1'b0;
        run_frames(59);
        check("inv1_frame59", player_invulnerable, 1);
        run_frames(1);

        // 500 hit cycles in one frame cost exactly one life.
        expect_ev("hit_500_cycles", 1, 2, 3, 0, 0, 1, 0, frame_no + 1);
        frame(520, 500, 0, 0, 3'b000);

        // Hits while invulnerable are ignored.
        expect_ev("p1_inv_end", 1, 2, 3, 0, 0, 0, 0, frame_no + 60);
        frame(8, 7, 0, 0, 3'b000);
        run_frames(59);

        // A hit on the frame-start cycle is charged one frame later.
        expect_ev("sof_hit_deferred", 1, 1, 3, 0, 0, 1, 0, frame_no + 2);
        frame(4, 0, 0, 0, 3'b001);
        check("sof_hit_lives1_unchanged", lives1, 2);
        frame(4, 0, 0, 0, 3'b000);

        // Player 2 loses two lives.
        expect_ev("p2_hit1",     1, 1, 2, 0, 0, 1, 1, frame_no + 1);
        expect_ev("p1_inv_end2", 1, 1, 2, 0, 0, 0, 1, frame_no + 60);
        expect_ev("p2_inv_end1", 1, 1, 2, 0, 0, 0, 0, frame_no + 61);
        frame(4, 0, 3, 0, 3'b000);
        run_frames(60);
        expect_ev("p2_hit2",     1, 1, 1, 0, 0, 0, 1, frame_no + 1);
        expect_ev("p2_inv_end2", 1, 1, 1, 0, 0, 0, 0, frame_no + 61);
        frame(4, 0, 3, 0, 3'b000);
        run_frames(60);

        // Both die in the frame the door is touched: GAME_OVER wins. Start key held throughout.
        start_button = 1'b1;
        expect_ev("both_dead_with_door", 3, 0, 0, 0, 0, 1, 1, frame_no + 1);
        frame(4, 3, 3, 3, 3'b000);
        repeat (6) tick();
        check("held_start_stays_game_over", game_state, 3);
        start_button = 1'b0;
        repeat (3) tick();
        expect_ev("start_edge_to_idle", 0, 0, 0, 0, 0, 1, 1, frame_no);
        start_button = 1'b1;
        tick();
        start_button = 1'b0;
        tick();
        check("idle_after_release", game_state, 0);

        // New game, then door -> LEVEL_DONE -> 90 frames -> next level, up to saturation at 7.
        expect_ev("restart",           1, 3, 3, 0, 1, 1, 1, frame_no);
        expect_ev("restart_pulse_end", 1, 3, 3, 0, 0, 1, 1, frame_no);
        start_button = 1'b1;
        tick();
        start_button = 1'b0;
        tick();
        for (int lv = 0; lv < 8; lv++) begin
            nxt = (lv < 7) ? lv + 1 : 7;
            expect_ev("enter_level_done",   2, 3, 3, lv,  0, 1, 1, frame_no + 1);
            expect_ev("level_up",           1, 3, 3, nxt, 1, 1, 1, frame_no + 91);
            expect_ev("level_up_pulse_end", 1, 3, 3, nxt, 0, 1, 1, frame_no + 91);
            frame(4, 0, 0, 2, 3'b000);
            for (int f = 0; f < 90; f++) frame(4, 2, 2, 2, 3'b000);
        end

        // Reset lands on the frame-start edge that would have returned to PLAY.
        expect_ev("enter_level_done_final", 2, 3, 3, 7, 0, 1, 1, frame_no + 1);
        frame(4, 0, 0, 2, 3'b000);
        run_frames(89);
        expect_ev("reset_mid_level_done", 0, 0, 0, 0, 0, 0, 0, frame_no + 1);
        repeat (3) tick();
        startOfFrame = 1'b1;
        reset        = 1'b1;
        tick();
        frame_no++;
        startOfFrame = 1'b0;
        reset        = 1'b0;
        check_reset_outputs("midreset");
        repeat (12) tick();
        run_frames(3);
        check("idle_after_midreset", game_state, 0);

        repeat (2) tick();
        check("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
